// File: rtl/s2p_pkg.sv
// Shared sizing helpers and default parameters for the serial-to-parallel stream packer.
package s2p_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_LANES     = 1;
    localparam bit DEF_MSB_FIRST = 1'b1;

    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

    function automatic int cnt_w(input int nbeats);
        return $clog2(nbeats + 1);
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Single-entry valid/ready holding register for an assembled word and its beat count.
module s2p_out_reg #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [CW-1:0] load_count,
    input  logic          take,
    output logic          full,
    output logic          ready_up,
    output logic [DW-1:0] data,
    output logic [CW-1:0] count
);

    // Upstream may load whenever the slot is empty or is being drained this cycle.
    assign ready_up = !full || take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            full  <= 1'b1;
            data  <= load_data;
            count <= load_count;
        end else if (take) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Packs LANES-bit serial beats into WIDTH-bit words with early termination and valid/ready on both sides.
module serial_to_parallel_stream
    import s2p_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     serial_valid,
    output logic                                     serial_ready,
    input  logic [LANES-1:0]                         serial_data,
    input  logic                                     serial_last,
    output logic                                     parallel_valid,
    input  logic                                     parallel_ready,
    output logic [WIDTH-1:0]                         parallel_data,
    output logic [cnt_w(beats(WIDTH, LANES))-1:0]    parallel_count
);

    localparam int BEATS = beats(WIDTH, LANES);
    localparam int CNT_W = cnt_w(BEATS);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_param_check
        $error("serial_to_parallel_stream: WIDTH must be a non-zero multiple of LANES");
    end

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_beat;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] word_count;
    logic             accept;
    logic             word_done;

    assign accept     = serial_valid && serial_ready;
    assign word_done  = accept && (serial_last || idx == IDX_W'(BEATS - 1));
    assign word_count = CNT_W'(idx) + CNT_W'(1);

    // Accumulator with the current beat dropped into its slot; untouched slots stay 0.
    always_comb begin
        acc_beat = acc;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IDX_W'(k)) begin
                if (MSB_FIRST)
                    acc_beat[WIDTH-1-k*LANES -: LANES] = serial_data;
                else
                    acc_beat[k*LANES +: LANES] = serial_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            if (word_done) begin
                acc <= '0;
                idx <= '0;
            end else begin
                acc <= acc_beat;
                idx <= idx + 1'b1;
            end
        end
    end

    s2p_out_reg #(
        .DW(WIDTH),
        .CW(CNT_W)
    ) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (word_done),
        .load_data  (acc_beat),
        .load_count (word_count),
        .take       (parallel_ready),
        .full       (parallel_valid),
        .ready_up   (serial_ready),
        .data       (parallel_data),
        .count      (parallel_count)
    );

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Directed table plus hand sequences and a random scoreboard over three packer configurations.
module tb_serial_to_parallel_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: 8/1 MSB-first, B: 8/1 LSB-first (shared inputs), C: 8/2 MSB-first
    logic       sv_ab = 0, sl_ab = 0, pr_ab = 1;
    logic [0:0] sd_ab = '0;
    logic       sr_a, pv_a, sr_b, pv_b;
    logic [7:0] pd_a, pd_b;
    logic [3:0] pc_a, pc_b;

    logic       sv_c = 0, sl_c = 0, pr_c = 1;
    logic [1:0] sd_c = '0;
    logic       sr_c, pv_c;
    logic [7:0] pd_c;
    logic [2:0] pc_c;

    serial_to_parallel_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .serial_valid(sv_ab), .serial_ready(sr_a),
        .serial_data(sd_ab), .serial_last(sl_ab), .parallel_valid(pv_a),
        .parallel_ready(pr_ab), .parallel_data(pd_a), .parallel_count(pc_a));

    serial_to_parallel_stream #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .serial_valid(sv_ab), .serial_ready(sr_b),
        .serial_data(sd_ab), .serial_last(sl_ab), .parallel_valid(pv_b),
        .parallel_ready(pr_ab), .parallel_data(pd_b), .parallel_count(pc_b));

    serial_to_parallel_stream #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .serial_valid(sv_c), .serial_ready(sr_c),
        .serial_data(sd_c), .serial_last(sl_c), .parallel_valid(pv_c),
        .parallel_ready(pr_c), .parallel_data(pd_c), .parallel_count(pc_c));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v, d, l, pr;
        logic       e_pv, e_sr;
        logic [7:0] e_a, e_b;
        logic [3:0] e_c;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] c;
    } exp_t;

    vec_t tbl[16];

    task automatic step_ab(input logic v, input logic d, input logic l, input logic pr);
        @(negedge clk);
        sv_ab = v; sd_ab[0] = d; sl_ab = l; pr_ab = pr;
        #1;
    endtask

    task automatic step_c(input logic v, input logic [1:0] d, input logic l, input logic pr);
        @(negedge clk);
        sv_c = v; sd_c = d; sl_c = l; pr_c = pr;
        #1;
    endtask

    task automatic chk_c(input string name, input logic pv, input logic [7:0] pd, input logic [2:0] pc);
        chk({name, ".valid"}, pv_c, pv);
        chk({name, ".data"},  pd_c, pd);
        chk({name, ".count"}, pc_c, pc);
    endtask

    task automatic chk_rst(input string name);
        chk({name, ".pv"}, {pv_a, pv_b, pv_c}, 3'b000);
        chk({name, ".pd"}, {pd_a, pd_b, pd_c}, 24'h0);
        chk({name, ".pc"}, {pc_a, pc_b, 1'b0, pc_c}, 12'h0);
        chk({name, ".sr"}, {sr_a, sr_b, sr_c}, 3'b111);
    endtask

    initial begin
        exp_t q[$];
        exp_t e;
        logic [1:0] bt[4];
        int   len, k, sent, got, cyc;
        logic have, hold, last4;

        //            v  d  l  pr pv sr  a      b      cnt
        tbl[0]  = '{1, 1, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[1]  = '{1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[2]  = '{1, 1, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[3]  = '{1, 1, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[4]  = '{1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[5]  = '{1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[6]  = '{1, 1, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[7]  = '{1, 0, 0, 1, 0, 1, 8'h00, 8'h00, 4'd0};
        tbl[8]  = '{0, 0, 0, 1, 1, 1, 8'hB2, 8'h4D, 4'd8};
        tbl[9]  = '{1, 1, 1, 1, 0, 1, 8'hB2, 8'h4D, 4'd8};
        tbl[10] = '{1, 0, 0, 0, 1, 0, 8'h80, 8'h01, 4'd1};
        tbl[11] = '{1, 0, 0, 1, 1, 1, 8'h80, 8'h01, 4'd1};
        tbl[12] = '{1, 1, 1, 1, 0, 1, 8'h80, 8'h01, 4'd1};
        tbl[13] = '{1, 1, 1, 1, 1, 1, 8'h40, 8'h02, 4'd2};
        tbl[14] = '{0, 0, 0, 1, 1, 1, 8'h80, 8'h01, 4'd1};
        tbl[15] = '{0, 0, 0, 1, 0, 1, 8'h80, 8'h01, 4'd1};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: 8/1 packing in both bit orders, last on beat 0, hold, simultaneous consume+complete
        for (int i = 0; i < 16; i++) begin
            step_ab(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].pr);
            chk($sformatf("row%0d.pv", i), {pv_a, pv_b}, {tbl[i].e_pv, tbl[i].e_pv});
            chk($sformatf("row%0d.sr", i), {sr_a, sr_b}, {tbl[i].e_sr, tbl[i].e_sr});
            chk($sformatf("row%0d.pd_a", i), pd_a, tbl[i].e_a);
            chk($sformatf("row%0d.pd_b", i), pd_b, tbl[i].e_b);
            chk($sformatf("row%0d.pc", i), {pc_a, pc_b}, {tbl[i].e_c, tbl[i].e_c});
        end
        step_ab(0, 0, 0, 1);

        // 8/2: short word with last, then full word with no bubble
        step_c(1, 2'b11, 0, 1); chk("c_b0.sr", sr_c, 1'b1);
        step_c(1, 2'b01, 1, 1); chk("c_b1.sr", sr_c, 1'b1); chk("c_b1.pv", pv_c, 1'b0);
        step_c(1, 2'b10, 0, 1); chk_c("c_short", 1'b1, 8'hD0, 3'd2); chk("c_f0.sr", sr_c, 1'b1);
        step_c(1, 2'b10, 0, 1); chk("c_f1.pv", pv_c, 1'b0); chk("c_f1.sr", sr_c, 1'b1);
        step_c(1, 2'b10, 0, 1); chk("c_f2.sr", sr_c, 1'b1);
        step_c(1, 2'b10, 0, 0); chk("c_f3.sr", sr_c, 1'b1);

        // Backpressure: word held, source beat held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step_c(1, 2'b11, 0, 0);
            chk_c($sformatf("c_hold%0d", i), 1'b1, 8'hAA, 3'd4);
            chk($sformatf("c_hold%0d.sr", i), sr_c, 1'b0);
        end
        step_c(1, 2'b11, 0, 1); chk("c_release.sr", sr_c, 1'b1);
        step_c(1, 2'b00, 0, 1); chk("c_drained.pv", pv_c, 1'b0);
        step_c(1, 2'b11, 0, 1);
        step_c(1, 2'b00, 0, 1);
        step_c(0, 2'b00, 0, 1); chk_c("c_after_bp", 1'b1, 8'hCC, 3'd4);
        step_c(0, 2'b00, 0, 1); chk("c_after_bp.drain", pv_c, 1'b0);

        // Random scoreboard: 100 words, random length/last/gaps/ready
        sent = 0; got = 0; cyc = 0; have = 0; hold = 0; k = 0; len = 1; last4 = 0;
        while (got < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            pr_c = ($urandom_range(0, 3) != 0);
            if (!have && sent < 100) begin
                len = $urandom_range(1, 4);
                last4 = $urandom_range(0, 1) != 0;
                e.d = '0;
                for (int i = 0; i < 4; i++) begin
                    bt[i] = 2'($urandom_range(0, 3));
                    if (i < len) e.d[7-2*i -: 2] = bt[i];
                end
                e.c = 3'(len);
                q.push_back(e);
                have = 1; k = 0; sent++;
            end
            if (!hold) sv_c = have && ($urandom_range(0, 4) != 0);
            sd_c = bt[k];
            sl_c = (k == len - 1) && (len < 4 || last4);
            #1;
            if (pv_c && pr_c) begin
                if (q.size() == 0) begin
                    chk("rand.extra_word", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rand.word%0d", got), {pc_c, pd_c}, {e.c, e.d});
                    got++;
                end
            end
            if (sv_c && sr_c) begin
                hold = 0;
                k++;
                if (k == len) have = 0;
            end else begin
                hold = sv_c;
            end
        end
        chk("rand.words_received", got, 100);
        sv_c = 0; pr_c = 1;

        // Reset mid-word: partial word discarded
        step_ab(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step_ab(1, 1, 0, 1);
        @(negedge clk);
        rst_n = 1'b0; sv_ab = 0; sv_c = 0;
        #1;
        chk_rst("in_reset0");
        @(negedge clk);
        #1;
        chk_rst("in_reset1");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_ab(1, i[0], 0, 1);
            chk($sformatf("post_rst.b%0d.pv", i), {pv_a, pv_b}, 2'b00);
        end
        step_ab(0, 0, 0, 1);
        chk("post_rst.pv", {pv_a, pv_b}, 2'b11);
        chk("post_rst.pd_a", pd_a, 8'h55);
        chk("post_rst.pd_b", pd_b, 8'hAA);
        chk("post_rst.pc", {pc_a, pc_b}, {4'd8, 4'd8});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_stream.md
Name: serial_to_parallel_stream

Overview:
- Parametrised successor of the single-bit deserialiser: packs LANES-bit serial beats into WIDTH-bit words.
- Selectable bit order; early word termination via serial_last, with beat count reported.
- Valid/ready handshake on both sides, so it can sit between a serial PHY/shift front-end and a backpressuring stream consumer.

Parameters:
- WIDTH, 8: output word width in bits; must be a multiple of LANES.
- LANES, 1: bits per serial beat; 1 <= LANES <= WIDTH.
- MSB_FIRST, 1: 1 = first beat fills the top of the word; 0 = first beat fills the bottom.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset.
- serial_valid  input  1  beat present on serial_data.
- serial_ready  output  1  block accepts a beat this cycle.
- serial_data  input  LANES  beat payload.
- serial_last  input  1  qualified by serial_valid; this beat ends the current word.
- parallel_valid  output  1  word held on parallel_data/parallel_count.
- parallel_ready  input  1  consumer takes the word this cycle.
- parallel_data  output  WIDTH  assembled word.
- parallel_count  output  CNT_W  beats in word, 1..BEATS; CNT_W = $clog2(BEATS+1).

Behaviour:
- Reset: async assert on rst_n low, release sync to clk.
  - Outputs on reset: parallel_valid=0, parallel_data=0, parallel_count=0.
  - Internal state on reset: accumulator=0, beat index=0.
  - serial_ready is combinational: 1 during and after reset.
- Derived constant: BEATS = WIDTH/LANES.
- Handshakes:
  - Input beat accepted when serial_valid && serial_ready.
  - Word consumed when parallel_valid && parallel_ready.
- serial_ready = !parallel_valid || parallel_ready (combinational; stalls input while the output word is held).
- Placement of beat k (0-based index within word):
  - MSB_FIRST=1: accumulator[WIDTH-1-k*LANES -: LANES].
  - MSB_FIRST=0: accumulator[k*LANES +: LANES].
  - Positions not written in a partial word read as 0.
- Word completion on an accepted beat with index==BEATS-1 or serial_last=1:
  - Accumulator (including this beat) loads into parallel_data on the same edge.
  - parallel_count <= index+1; parallel_valid <= 1.
  - Accumulator clears; index returns to 0.
- Latency: parallel_valid rises the cycle after the completing beat is accepted.
- Throughput: full rate, one beat per clock.
  - Back-to-back words with parallel_ready=1 need no bubble.
  - With LANES==WIDTH, every accepted beat is a word.
- Non-completing accepted beat: write accumulator slot, index+1; output register untouched.
- Output hold: while parallel_valid && !parallel_ready, data and count stay stable and serial_ready=0.
- Consume with no simultaneous completion: parallel_valid <= 0; data and count keep their last value.
- Simultaneous consume and completion: new word replaces old, parallel_valid stays 1.
- serial_last on beat index BEATS-1: ordinary full word, count=BEATS.
- serial_last on beat 0: count=1.
- serial_valid with serial_ready=0: no state change; source must hold the beat (AXI-style).
- Reset mid-word: partial accumulator discarded, no word emitted.
- Elaboration: WIDTH % LANES != 0 or LANES > WIDTH triggers a $error in an initial/generate check.

Decomposition:
- Package s2p_pkg holds:
  - function beats(width, lanes);
  - function cnt_w(beats) = $clog2(beats+1);
  - localparam defaults.
- One natural sub-module: s2p_out_reg.
  - Single-entry valid/ready holding register for data+count.
  - Exposes load, full and ready-upstream.
- Accumulator, index counter and placement logic stay in the top.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles, parallel_ready=1 -> parallel_data=0xB2, count=8, valid exactly one cycle after 8th beat.
- Same bits with MSB_FIRST=0 -> parallel_data=0x4D, count=8.
- WIDTH=8, LANES=2, MSB_FIRST=1; beats 2'b11, 2'b01 with last on second -> parallel_data=0xD0, count=2. Then full word 2'b10,2'b10,2'b10,2'b10 -> 0xAA, count=4, no bubble between words.
- Backpressure: hold parallel_ready=0 after first word completes -> serial_ready=0, data stable for 5 cycles, source beat held. Raise ready -> word consumed and next beat accepted the same cycle.
- Simultaneous: parallel_ready=1 on the cycle a new word completes -> parallel_valid stays high, data switches to new word, no word lost or duplicated (scoreboard against 100 random words with random last/ready).
- Assert rst_n low after 3 of 8 beats, then release and send 8 beats -> only the post-reset word appears, count=8; all outputs 0 while in reset.
